iomem_arbiter: RTL and testbench
================================

Name: iomem_arbiter

Overview:
- Two-master, one-slave arbiter for the processor-style iomem valid/ready memory port.
- Lets two requesters share the single external iomem port that drives the memory model, e.g. instruction fetch plus data, or core plus debug/DMA.
- Round-robin grant, one transaction in flight.
- Request fields are registered at grant; response is registered back to the granted master.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports; the strobe width is DATA_WIDTH/8.
- TIMEOUT_CYC, 256, cycles to wait for down_ready before aborting; used only with the optional feature.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- m0_valid_i  in  1  master 0 request
- m0_ready_o  out  1  master 0 completion pulse
- m0_wstrb_i  in  DATA_WIDTH/8  master 0 byte strobes; 0 means read
- m0_addr_i  in  ADDR_WIDTH  master 0 address
- m0_wdata_i  in  DATA_WIDTH  master 0 write data
- m0_rdata_o  out  DATA_WIDTH  master 0 read data
- m1_*  same set as m0_*, for master 1
- down_valid_o  out  1  slave request
- down_ready_i  in  1  slave completion
- down_wstrb_o  out  DATA_WIDTH/8  slave byte strobes
- down_addr_o  out  ADDR_WIDTH  slave address
- down_wdata_o  out  DATA_WIDTH  slave write data
- down_rdata_i  in  DATA_WIDTH  slave read data
- err_o  out  1  timeout pulse; tied to 0 without the optional feature

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; last_grant=1, so m0 wins the first tie.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If any mX_valid_i is sampled, pick a winner: the only requester, or on a tie the master not equal to last_grant.
  - Register the winner's addr/wdata/wstrb into the down_* outputs, set down_valid_o=1, set last_grant to the winner, go to REQ.
- REQ:
  - down_valid_o and all down_* fields are held stable until down_ready_i is sampled at 1.
  - On that edge: capture down_rdata_i into the winner's mX_rdata_o, set the winner's mX_ready_o=1, drop down_valid_o, go to RESP.
- RESP:
  - mX_ready_o is high for exactly this one cycle, then returns to 0. FSM returns to IDLE.
  - No grant is made in RESP, because the master's valid is still high in this cycle.
- Master contract: a master holds valid and its fields until it sees ready, then drops or changes them.
- Latency:
  - Valid sampled at edge N gives down_valid_o high from N+1.
  - down_ready_i sampled at edge M gives mX_ready_o high from M+1.
  - Minimum master-visible turnaround is 3 cycles when the slave answers in 1 cycle.
- Non-granted master: its ready stays 0, its rdata is unchanged, and its request stays pending, to be granted at the next IDLE.
- Granted master drops valid during REQ: ignored. The transaction completes downstream and the ready pulse is still issued.
- down_ready_i while in IDLE or RESP: ignored.
- Writes: mX_rdata_o still loads down_rdata_i; the value is don't-care for the master.
- Reset mid-operation: all outputs clear immediately (asynchronously), and any in-flight transaction is dropped.

Optional Feature:
- Macro: IOMEM_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to REQ and counts each REQ cycle.
  - If it reaches TIMEOUT_CYC with no down_ready_i: drop down_valid_o, load mX_rdata_o=32'hDEAD_BEEF, pulse mX_ready_o and err_o for one cycle, go to RESP.
  - If down_ready_i arrives on the terminal cycle, it wins: a normal completion, no error.
- Undefined: no counter; REQ waits forever; err_o is constant 0.

Decomposition:
- Package iomem_arb_pkg holds:
  - the state encoding (IDLE/REQ/RESP);
  - the master-index type;
  - the constant TIMEOUT_RDATA = 32'hDEAD_BEEF.
- One sub-module, iomem_rr_pick: combinational 2-way round-robin picker. Inputs: req[1:0], last_grant. Outputs: gnt_valid, gnt_idx.

Test Plan:
1. m0 read of 0x4000_0010 alone; slave returns 0x1234_5678 one cycle after valid -> down_addr_o=0x4000_0010, down_wstrb_o=0; m0_ready_o is a 1-cycle pulse with m0_rdata_o=0x1234_5678; m1_ready_o stays 0.
2. m0 and m1 request in the same cycle after reset -> m0 is served first, then m1 with no extra idle. A second simultaneous pair is served m1 first (alternation).
3. m1 write to 0x4000_0020, wdata 0xCAFE_F00D, wstrb 4'b0011; slave delays ready 5 cycles -> down_* fields stable for all 5 cycles; m1_ready_o pulses once; a memory readback returns the low halfword updated.
4. rst_i asserted 2 cycles into REQ -> down_valid_o=0 with no clock edge; after release, last_grant=1 and a fresh m1 request is served correctly.
5. With IOMEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, slave never ready -> 8 cycles after REQ entry: m0_rdata_o=0xDEAD_BEEF, m0_ready_o=1 and err_o=1 for one cycle. Without the macro: down_valid_o stays 1 for 1000 cycles and err_o=0.
6. m0 drops valid one cycle into REQ -> downstream transaction still completes and m0_ready_o still pulses once.

Source files
------------

// File: rtl/iomem_arb_pkg.sv
// rtl/iomem_arb_pkg.sv - shared state encoding, master index type and constants for iomem_arbiter
package iomem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        MST_0 = 1'b0,
        MST_1 = 1'b1
    } master_idx_t;

    // Read data handed back to a master whose transaction was aborted.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/iomem_rr_pick.sv
// rtl/iomem_rr_pick.sv - combinational two-way round-robin picker
//
// Ports:
//   req[1:0]    pending requests, bit N = master N
//   last_grant  master granted most recently
//   gnt_valid   at least one request is pending
//   gnt_idx     winning master; on a tie the one not equal to last_grant
module iomem_rr_pick
    import iomem_arb_pkg::*;
(
    input  logic [1:0]  req,
    input  master_idx_t last_grant,
    output logic        gnt_valid,
    output master_idx_t gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = MST_0;
        case (req)
            2'b10:   gnt_idx = MST_1;
            2'b11:   gnt_idx = (last_grant == MST_1) ? MST_0 : MST_1;
            default: gnt_idx = MST_0;
        endcase
    end

endmodule

// File: rtl/iomem_arbiter.sv
// rtl/iomem_arbiter.sv - two-master round-robin arbiter for the iomem valid/ready port
//
// One transaction in flight. Request fields are registered at grant and held
// until the slave answers; the response is registered back to the owner as a
// one-cycle ready pulse. Optional request timeout: define IOMEM_ARB_TIMEOUT_EN.
//
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   mX_valid_i/addr_i/wdata_i/wstrb_i  master X request (wstrb 0 = read)
//   mX_ready_o/rdata_o                 master X completion pulse and read data
//   down_valid_o/addr_o/wdata_o/wstrb_o  slave request
//   down_ready_i/rdata_i               slave completion and read data
//   err_o                              timeout pulse (0 without the timeout)
module iomem_arbiter
    import iomem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    m0_valid_i,
    output logic                    m0_ready_o,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,

    input  logic                    m1_valid_i,
    output logic                    m1_ready_o,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,

    output logic                    down_valid_o,
    input  logic                    down_ready_i,
    output logic [DATA_WIDTH/8-1:0] down_wstrb_o,
    output logic [ADDR_WIDTH-1:0]   down_addr_o,
    output logic [DATA_WIDTH-1:0]   down_wdata_o,
    input  logic [DATA_WIDTH-1:0]   down_rdata_i,

    output logic                    err_o
);

    arb_state_t  state_q;
    arb_state_t  state_d;
    master_idx_t last_grant_q;
    master_idx_t owner_q;

    logic        gnt_valid;
    master_idx_t gnt_idx;
    logic        load_req;
    logic        complete;
    logic        abort;

    logic [DATA_WIDTH-1:0] resp_data;

    iomem_rr_pick u_pick (
        .req        ({m1_valid_i, m0_valid_i}),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

`ifdef IOMEM_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic        err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
        end else if (load_req) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_REQ) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    // A slave answer on the terminal cycle takes precedence over the abort.
    assign abort = (state_q == ST_REQ) && !down_ready_i &&
                   (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= abort;
        end
    end

    assign err_o = err_q;
`else
    assign abort = 1'b0;
    assign err_o = 1'b0;
`endif

    assign resp_data = abort ? DATA_WIDTH'(TIMEOUT_RDATA) : down_rdata_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (gnt_valid) state_d = ST_REQ;
            ST_REQ:  if (down_ready_i || abort) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load_req = 1'b0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: load_req = gnt_valid;
            ST_REQ:  complete = down_ready_i || abort;
            default: ;
        endcase
    end

    // Datapath registers; ready pulses default low so they last one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= MST_1;
            owner_q      <= MST_0;
            down_valid_o <= 1'b0;
            down_wstrb_o <= '0;
            down_addr_o  <= '0;
            down_wdata_o <= '0;
            m0_ready_o   <= 1'b0;
            m0_rdata_o   <= '0;
            m1_ready_o   <= 1'b0;
            m1_rdata_o   <= '0;
        end else begin
            m0_ready_o <= 1'b0;
            m1_ready_o <= 1'b0;
            if (load_req) begin
                owner_q      <= gnt_idx;
                last_grant_q <= gnt_idx;
                down_valid_o <= 1'b1;
                if (gnt_idx == MST_1) begin
                    down_wstrb_o <= m1_wstrb_i;
                    down_addr_o  <= m1_addr_i;
                    down_wdata_o <= m1_wdata_i;
                end else begin
                    down_wstrb_o <= m0_wstrb_i;
                    down_addr_o  <= m0_addr_i;
                    down_wdata_o <= m0_wdata_i;
                end
            end
            if (complete) begin
                down_valid_o <= 1'b0;
                if (owner_q == MST_1) begin
                    m1_ready_o <= 1'b1;
                    m1_rdata_o <= resp_data;
                end else begin
                    m0_ready_o <= 1'b1;
                    m0_rdata_o <= resp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_iomem_arbiter.sv
// tb/tb_iomem_arbiter.sv - directed self-checking bench for iomem_arbiter
module tb_iomem_arbiter;

    logic        clk;
    logic        rst_i;
    logic        m0_valid_i, m1_valid_i;
    logic        m0_ready_o, m1_ready_o;
    logic [3:0]  m0_wstrb_i, m1_wstrb_i;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic [31:0] m0_wdata_i, m1_wdata_i;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        down_valid_o;
    logic        down_ready_i;
    logic [3:0]  down_wstrb_o;
    logic [31:0] down_addr_o;
    logic [31:0] down_wdata_o;
    logic [31:0] down_rdata_i;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:15];
    int          slave_delay = 0;
    logic        slave_en = 1'b1;
    int          wait_cnt;

    iomem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYC(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .m0_valid_i   (m0_valid_i),
        .m0_ready_o   (m0_ready_o),
        .m0_wstrb_i   (m0_wstrb_i),
        .m0_addr_i    (m0_addr_i),
        .m0_wdata_i   (m0_wdata_i),
        .m0_rdata_o   (m0_rdata_o),
        .m1_valid_i   (m1_valid_i),
        .m1_ready_o   (m1_ready_o),
        .m1_wstrb_i   (m1_wstrb_i),
        .m1_addr_i    (m1_addr_i),
        .m1_wdata_i   (m1_wdata_i),
        .m1_rdata_o   (m1_rdata_o),
        .down_valid_o (down_valid_o),
        .down_ready_i (down_ready_i),
        .down_wstrb_o (down_wstrb_o),
        .down_addr_o  (down_addr_o),
        .down_wdata_o (down_wdata_o),
        .down_rdata_i (down_rdata_i),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave memory: answers slave_delay negedges after it first sees a request.
    initial begin
        down_ready_i = 1'b0;
        down_rdata_i = '0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (down_ready_i) begin
                down_ready_i = 1'b0;
                wait_cnt = 0;
            end else if (down_valid_o && slave_en) begin
                if (wait_cnt == slave_delay) begin
                    down_ready_i = 1'b1;
                    down_rdata_i = mem[down_addr_o[5:2]];
                    for (int b = 0; b < 4; b++)
                        if (down_wstrb_o[b]) mem[down_addr_o[5:2]][b*8 +: 8] = down_wdata_o[b*8 +: 8];
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        rst_i = 1'b1;
        m0_valid_i = 1'b0;
        m1_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_ready(input int idx, input int max_cyc, output logic ok, output logic [31:0] rd);
        ok = 1'b0;
        rd = '0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            if (idx == 0 && m0_ready_o) begin ok = 1'b1; rd = m0_rdata_o; end
            if (idx == 1 && m1_ready_o) begin ok = 1'b1; rd = m1_rdata_o; end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        m0_valid_i = 0; m0_wstrb_i = 0; m0_addr_i = 0; m0_wdata_i = 0;
        m1_valid_i = 0; m1_wstrb_i = 0; m1_addr_i = 0; m1_wdata_i = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({down_valid_o, m0_ready_o, m1_ready_o, err_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {down_valid_o, m0_ready_o, m1_ready_o, err_o});
        end
        checks++;
        if ({down_addr_o, down_wdata_o, down_wstrb_o, m0_rdata_o, m1_rdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_data got addr %h wdata %h m0 %h m1 %h want 0", down_addr_o, down_wdata_o, m0_rdata_o, m1_rdata_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        mem[4] = 32'h1234_5678;
        slave_delay = 0;
        m0_valid_i = 1; m0_addr_i = 32'h4000_0010; m0_wstrb_i = 4'b0000;
        @(negedge clk);
        checks++;
        if ({down_valid_o, down_addr_o, down_wstrb_o} !== {1'b1, 32'h4000_0010, 4'b0000}) begin
            errors++;
            $display("FAIL single_req got v%b %h %b want v1 40000010 0000", down_valid_o, down_addr_o, down_wstrb_o);
        end
        @(negedge clk);
        checks++;
        if ({m0_ready_o, m1_ready_o, down_valid_o} !== 3'b100 || m0_rdata_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL single_resp got rdy %b%b dv %b rdata %h want 10 0 12345678", m0_ready_o, m1_ready_o, down_valid_o, m0_rdata_o);
        end
        m0_valid_i = 0;
        @(negedge clk);
        checks++;
        if ({m0_ready_o, m1_ready_o} !== 2'b00) begin
            errors++;
            $display("FAIL single_pulse_end got %b want 00", {m0_ready_o, m1_ready_o});
        end
        @(negedge clk);
    endtask

    task automatic test_tie();
        logic        ok;
        logic [31:0] rd;
        pulse_reset();
        mem[1] = 32'hA0A0_0001; mem[2] = 32'hA0A0_0002; mem[3] = 32'hA0A0_0003;
        slave_delay = 0;
        m0_valid_i = 1; m0_addr_i = 32'h4000_0004; m0_wstrb_i = 0;
        m1_valid_i = 1; m1_addr_i = 32'h4000_0008; m1_wstrb_i = 0;
        @(negedge clk);
        checks++;
        if (down_addr_o !== 32'h4000_0004) begin
            errors++;
            $display("FAIL tie_first got %h want 40000004", down_addr_o);
        end
        @(negedge clk);
        checks++;
        if ({m0_ready_o, m1_ready_o} !== 2'b10 || m0_rdata_o !== 32'hA0A0_0001) begin
            errors++;
            $display("FAIL tie_m0_resp got %b %h want 10 a0a00001", {m0_ready_o, m1_ready_o}, m0_rdata_o);
        end
        m0_addr_i = 32'h4000_000C;
        @(negedge clk);
        checks++;
        if (down_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL tie_resp_idle got %b want 0", down_valid_o);
        end
        @(negedge clk);
        checks++;
        if ({down_valid_o, down_addr_o} !== {1'b1, 32'h4000_0008}) begin
            errors++;
            $display("FAIL tie_second_m1 got v%b %h want v1 40000008", down_valid_o, down_addr_o);
        end
        @(negedge clk);
        checks++;
        if ({m0_ready_o, m1_ready_o} !== 2'b01 || m1_rdata_o !== 32'hA0A0_0002 || m0_rdata_o !== 32'hA0A0_0001) begin
            errors++;
            $display("FAIL tie_m1_resp got %b m1 %h m0 %h want 01 a0a00002 a0a00001", {m0_ready_o, m1_ready_o}, m1_rdata_o, m0_rdata_o);
        end
        m1_valid_i = 0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({down_valid_o, down_addr_o} !== {1'b1, 32'h4000_000C}) begin
            errors++;
            $display("FAIL tie_third_m0 got v%b %h want v1 4000000c", down_valid_o, down_addr_o);
        end
        wait_ready(0, 10, ok, rd);
        checks++;
        if (ok !== 1'b1 || rd !== 32'hA0A0_0003) begin
            errors++;
            $display("FAIL tie_third_resp got ok %b %h want 1 a0a00003", ok, rd);
        end
        m0_valid_i = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_write_delay();
        logic        ok;
        logic [31:0] rd;
        int          bad;
        int          pulses;
        mem[8] = 32'h1122_3344;
        slave_delay = 5;
        bad = 0;
        m1_valid_i = 1; m1_addr_i = 32'h4000_0020; m1_wdata_i = 32'hCAFE_F00D; m1_wstrb_i = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if ({down_valid_o, down_addr_o, down_wdata_o, down_wstrb_o, m1_ready_o} !==
                {1'b1, 32'h4000_0020, 32'hCAFE_F00D, 4'b0011, 1'b0}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL write_hold got %0d unstable cycles want 0", bad);
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (m1_ready_o) pulses++;
            if (i == 0) m1_valid_i = 0;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL write_pulses got %0d want 1", pulses);
        end
        slave_delay = 0;
        m1_valid_i = 1; m1_wstrb_i = 4'b0000; m1_wdata_i = 0;
        wait_ready(1, 10, ok, rd);
        checks++;
        if (ok !== 1'b1 || rd !== 32'h1122_F00D) begin
            errors++;
            $display("FAIL write_readback got ok %b %h want 1 1122f00d", ok, rd);
        end
        m1_valid_i = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_drop_valid();
        int pulses;
        slave_delay = 3;
        m0_valid_i = 1; m0_addr_i = 32'h4000_0010; m0_wstrb_i = 0;
        @(negedge clk);
        m0_valid_i = 0;
        @(negedge clk);
        checks++;
        if (down_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL drop_hold got %b want 1", down_valid_o);
        end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m0_ready_o) begin
                pulses++;
                checks++;
                if (m0_rdata_o !== 32'h1234_5678) begin
                    errors++;
                    $display("FAIL drop_rdata got %h want 12345678", m0_rdata_o);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL drop_pulses got %0d want 1", pulses);
        end
        slave_delay = 0;
    endtask

    task automatic test_reset_mid();
        logic        ok;
        logic [31:0] rd;
        slave_delay = 20;
        m0_valid_i = 1; m0_addr_i = 32'h4000_0004; m0_wstrb_i = 0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (down_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got %b want 1", down_valid_o);
        end
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({down_valid_o, m1_rdata_o} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rstmid_async got v%b m1 %h want v0 0", down_valid_o, m1_rdata_o);
        end
        m0_valid_i = 0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        slave_delay = 0;
        @(negedge clk);
        m1_valid_i = 1; m1_addr_i = 32'h4000_0010; m1_wstrb_i = 0;
        @(negedge clk);
        checks++;
        if ({down_valid_o, down_addr_o} !== {1'b1, 32'h4000_0010}) begin
            errors++;
            $display("FAIL rstmid_grant got v%b %h want v1 40000010", down_valid_o, down_addr_o);
        end
        wait_ready(1, 10, ok, rd);
        checks++;
        if (ok !== 1'b1 || rd !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rstmid_resp got ok %b %h want 1 12345678", ok, rd);
        end
        m1_valid_i = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int bad;
        slave_en = 1'b0;
        bad = 0;
        m0_valid_i = 1; m0_addr_i = 32'h4000_0000; m0_wstrb_i = 0;
`ifdef IOMEM_ARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if ({down_valid_o, err_o, m0_ready_o} !== 3'b100) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL tmo_wait got %0d bad cycles want 0", bad);
        end
        @(negedge clk);
        checks++;
        if ({m0_ready_o, err_o, down_valid_o} !== 3'b110 || m0_rdata_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL tmo_abort got rdy/err/dv %b %h want 110 deadbeef", {m0_ready_o, err_o, down_valid_o}, m0_rdata_o);
        end
        m0_valid_i = 0;
        @(negedge clk);
        checks++;
        if ({m0_ready_o, err_o} !== 2'b00) begin
            errors++;
            $display("FAIL tmo_pulse_end got %b want 00", {m0_ready_o, err_o});
        end
`else
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if ({down_valid_o, err_o, m0_ready_o} !== 3'b100) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL notmo_hold got %0d bad cycles want 0", bad);
        end
        pulse_reset();
`endif
        slave_en = 1'b1;
        m0_valid_i = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_write_delay();
        test_drop_valid();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
